// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Response/request bundles are fixed at 32-bit data.
package dmem_pkg;

    localparam int WORD_OFFSET_BITS = 2;
    localparam int DATA_W           = 32;
    localparam int ADDR_W           = 32;
    localparam int BE_W             = DATA_W / 8;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // Replace the enabled bytes of old_word with the matching bytes of new_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and no write-to-read bypass.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = storage[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; only slots between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked memory responder: valid/ready requests in, one in-order
// response per request out after LATENCY cycles, back-pressured by an
// outstanding-request counter.
// Optional feature macro: DMEM_RESPONDER_ERR_CHECK_EN (misaligned or
// out-of-range addresses fault instead of wrapping).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [AWIDTH-1:0]   req_addr_i,
    input  logic [DWIDTH-1:0]   req_wdata_i,
    input  logic [DWIDTH/8-1:0] req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DWIDTH-1:0]   rsp_rdata_o,
    output logic                rsp_err_o
);

    localparam int IDX_BITS = $clog2(DEPTH_WORDS);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STAGES   = LATENCY - 1;

    // NOTE: the word array has no reset; contents must survive reset and a
    // reset loop over every word would block RAM inference.
    logic [DWIDTH-1:0]   mem [DEPTH_WORDS];

    logic [IDX_BITS-1:0] idx;
    logic                req_err;
    logic                accept;
    logic                rsp_fire;
    logic [CNT_W-1:0]    cnt;
    rsp_t                acc_rsp;
    logic                fifo_push;
    rsp_t                fifo_wdata;
    logic [$bits(rsp_t)-1:0] fifo_head;
    rsp_t                head_rsp;
    logic                fifo_full;
    logic                fifo_empty;

    assign idx = req_addr_i[IDX_BITS+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    assign req_err = (|req_addr_i[WORD_OFFSET_BITS-1:0])
                   | (|req_addr_i[AWIDTH-1:IDX_BITS+WORD_OFFSET_BITS]);
`else
    // Upper bits wrap and the byte offset is ignored in this build.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[AWIDTH-1:IDX_BITS+WORD_OFFSET_BITS],
                                req_addr_i[WORD_OFFSET_BITS-1:0]};
    assign req_err = 1'b0;
`endif

    // Ready depends only on the registered counter, never on rsp_ready_i.
    assign req_ready_o = (cnt < CNT_W'(FIFO_DEPTH));
    assign accept      = req_valid_i & req_ready_o & ~reset;
    assign rsp_fire    = rsp_valid_o & rsp_ready_i;

    // Response captured at accept: write and faulting responses carry zero data.
    always_comb begin
        // NOTE: combinational blocks assign every output first with blocking
        // '=' so no path leaves a value held, which would infer a latch.
        acc_rsp       = '0;
        acc_rsp.err   = req_err;
        if (!req_we_i && !req_err) acc_rsp.rdata = mem[idx];
    end

    // Commit enabled write bytes at the accept edge; faulting writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && req_we_i && !req_err) begin
            mem[idx] <= merge_bytes(mem[idx], req_wdata_i, req_be_i);
        end
    end

    // Outstanding requests: accepted but not yet handed back.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, rsp_fire})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    generate
        if (STAGES == 0) begin : g_no_delay
            assign fifo_push  = accept;
            assign fifo_wdata = acc_rsp;
        end else begin : g_delay
            logic [STAGES-1:0] dl_valid;
            rsp_t              dl_rsp [STAGES];

            // Valid bits of the delay line; cleared so reset drops in-flight work.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dl_valid <= '0;
                end else begin
                    dl_valid[0] <= accept;
                    for (int i = 1; i < STAGES; i++) dl_valid[i] <= dl_valid[i-1];
                end
            end

            // Payload of the delay line; qualified by the valid bits above.
            always_ff @(posedge clk) begin
                dl_rsp[0] <= acc_rsp;
                for (int i = 1; i < STAGES; i++) dl_rsp[i] <= dl_rsp[i-1];
            end

            assign fifo_push  = dl_valid[STAGES-1];
            assign fifo_wdata = dl_rsp[STAGES-1];
        end
    endgenerate

    // The counter bounds delay-line plus FIFO occupancy, so pushes never hit full.
    sync_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (rsp_fire),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

    assign head_rsp    = fifo_head;
    assign rsp_valid_o = ~fifo_empty;
    // Masking keeps outputs at zero while idle without resetting FIFO storage.
    assign rsp_rdata_o = rsp_valid_o ? head_rsp.rdata : '0;
    assign rsp_err_o   = rsp_valid_o & head_rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. A transaction-level
// model (word array + queue of expected responses with due cycles) predicts
// ready/valid/data every cycle.
module tb_dmem_responder;

    localparam int AWIDTH      = 32;
    localparam int DWIDTH      = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;
    localparam int FIFO_DEPTH  = 4;

`ifdef DMEM_RESPONDER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready_o;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid_o;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    always #5 clk = ~clk;

    dmem_responder #(
        .AWIDTH      (AWIDTH),
        .DWIDTH      (DWIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic [31:0] ref_mem [DEPTH_WORDS];
    exp_t        q [$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          last_acc;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply one accepted request to the model.
    function automatic void model_accept();
        exp_t        e;
        int          widx;
        bit          err;
        widx   = int'((req_addr / 4) % DEPTH_WORDS);
        err    = ERR_EN && (((req_addr % 4) != 0) || (req_addr >= DEPTH_WORDS * 4));
        e.err  = err;
        e.due  = cyc + LATENCY;
        e.rdata = 32'h0;
        if (req_we) begin
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[b]) ref_mem[widx][8*b +: 8] = req_wdata[8*b +: 8];
            end
        end else if (!err) begin
            e.rdata = ref_mem[widx];
        end
        q.push_back(e);
    endfunction

    // One clock: compare at negedge, advance model at posedge, return #1 after.
    task automatic tick();
        bit exp_valid;
        bit acc;
        bit hs;
        @(negedge clk);
        exp_valid = (q.size() > 0) && (cyc >= q[0].due);
        acc = !reset && req_valid && (q.size() < FIFO_DEPTH);
        hs  = !reset && exp_valid && rsp_ready;
        if (!reset) begin
            check("req_ready", req_ready_o, q.size() < FIFO_DEPTH);
            check("rsp_valid", rsp_valid_o, exp_valid);
            check("rsp_rdata", rsp_rdata_o, exp_valid ? q[0].rdata : 32'h0);
            check("rsp_err",   rsp_err_o,   exp_valid ? q[0].err : 1'b0);
            if (hs) begin
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
            end
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (hs) void'(q.pop_front());
            if (acc) model_accept();
        end
        cyc++;
        last_acc = acc;
        #1;
    endtask

    task automatic issue(input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        tick();
    endtask

    initial begin
        int n_acc;
        int n_cyc;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Give every word a known value.
        for (int i = 0; i < DEPTH_WORDS; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);
        drain();

        // Write then read the next cycle.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        drain();
        check("wr_then_rd", last_rdata, 32'hDEADBEEF);

        // Byte-enable merge.
        issue(1'b1, 32'h20, 32'h11223344, 4'hF);
        issue(1'b1, 32'h20, 32'h000000AA << 8, 4'b0010);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        drain();
        check("byte_merge", last_rdata, 32'h1122AA44);

        // Backpressure: 6 back-to-back reads with the response side stalled.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 10; i++) begin
            req_addr = 32'(i * 4);
            tick();
            if (last_acc) n_acc++;
        end
        check("bp_accepted", n_acc, FIFO_DEPTH);
        rsp_ready = 1'b1;
        n_cyc = 0;
        while (n_acc < 6 && n_cyc < 40) begin
            req_addr = 32'(n_acc * 4);
            tick();
            if (last_acc) n_acc++;
            n_cyc++;
        end
        check("bp_total", n_acc, 6);
        req_valid = 1'b0;
        drain();

        // Streaming: one accept per cycle.
        req_valid = 1'b1;
        n_acc = 0;
        n_cyc = 0;
        while (n_acc < 16 && n_cyc < 40) begin
            req_addr = 32'(($urandom % DEPTH_WORDS) * 4);
            tick();
            if (last_acc) n_acc++;
            n_cyc++;
        end
        check("stream_cycles", n_cyc, 16);
        req_valid = 1'b0;
        drain();

        // Address wrap / fault handling.
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        drain();
`ifdef DMEM_RESPONDER_ERR_CHECK_EN
        issue(1'b0, 32'h2, 32'h0, 4'h0);
        drain();
        check("err_misaligned", last_err, 1'b1);
        issue(1'b1, 32'h1000, 32'h12345678, 4'hF);
        drain();
        check("err_range", last_err, 1'b1);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        drain();
        check("err_no_write", last_rdata, 32'hCAFEF00D);
`else
        issue(1'b0, 32'h1000, 32'h0, 4'h0);
        drain();
        check("wrap_word0", last_rdata, 32'hCAFEF00D);
        check("wrap_no_err", last_err, 1'b0);
`endif

        // Reset with three requests in flight.
        rsp_ready = 1'b0;
        issue(1'b1, 32'h40, 32'h5A5A5A5A, 4'hF);
        issue(1'b0, 32'h44, 32'h0, 4'h0);
        issue(1'b0, 32'h48, 32'h0, 4'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("rst_empty", q.size(), 0);
        issue(1'b0, 32'h40, 32'h0, 4'h0);
        drain();
        check("rst_write_kept", last_rdata, 32'h5A5A5A5A);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int sel;
            sel       = int'($urandom_range(0, 15));
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1);
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (sel == 0)      req_addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else if (sel == 1) req_addr = 32'($urandom_range(1, 255) * 4096 + $urandom_range(0, 4095));
            else               req_addr = 32'($urandom_range(0, 63) * 4);
            tick();
        end
        req_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the processor's memory request interface: accepts valid/ready read and write requests from an initiator (fetch or a load/store unit), services them against an internal word array, and returns exactly one in-order response per request after a fixed latency. It sits between the pipeline's memory initiators and backing storage, replacing the single-cycle, always-ready memory model with a handshaked, back-pressurable port.

## Interface
- AWIDTH, 32, byte address width
- DWIDTH, 32, data width; only 32 supported
- DEPTH_WORDS, 1024, words of storage; power of 2
- LATENCY, 2, cycles from request accept to earliest response valid; ≥1
- FIFO_DEPTH, 4, maximum outstanding requests; power of 2, ≥ LATENCY
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AWIDTH  byte address
- req_wdata_i  in  DWIDTH  write data
- req_be_i  in  DWIDTH/8  write byte enables; ignored for reads
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  initiator takes response
- rsp_rdata_o  out  DWIDTH  read data; 0 for write responses
- rsp_err_o  out  1  request faulted

## Operation
- Accept = req_valid_i & req_ready_o at a rising edge. Response handshake = rsp_valid_o & rsp_ready_i.
- Word index = req_addr_i[log2(DEPTH_WORDS)+1:2].
- Write: enabled bytes are committed at the accept edge. Read: the array is sampled at the accept edge, so a read accepted the cycle after a write to the same word returns the new data. A read and a write are never accepted in the same cycle, since there is one request port.
- Accepted requests pass through a LATENCY-1 stage delay line carrying {valid, rdata, err}, then enter the response FIFO. The FIFO head drives the rsp_* outputs.
- Outstanding counter `cnt`: +1 on accept, −1 on response handshake, unchanged when both occur.
- req_ready_o = (cnt < FIFO_DEPTH). It is a function of registered state only, with no combinational path from rsp_ready_i. At cnt == FIFO_DEPTH the port stalls even if a pop occurs in the same cycle.
- The counter guarantees the FIFO can never overflow. Responses are strictly in acceptance order.
- rsp_valid_o is low whenever the FIFO is empty. When rsp_valid_o is high, rsp_* are held stable until the handshake.
- Memory contents are not reset. Reset mid-operation discards in-flight and queued responses. Writes already accepted remain committed.

## Timing
- Reset values: req_ready_o = 1 in the first cycle after reset; rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, cnt = 0, delay-line valids = 0.
- Request accepted at the edge ending cycle t → rsp_valid_o high in cycle t+LATENCY when the FIFO is empty.
- Throughput: one request per cycle sustained while rsp_ready_i = 1 and FIFO_DEPTH ≥ LATENCY.
- Backpressure: with rsp_ready_i held 0, exactly FIFO_DEPTH requests are accepted, then req_ready_o drops. req_ready_o reasserts the cycle after the first response handshake.

## Configuration
- DMEM_RESPONDER_ERR_CHECK_EN defined:
  - A request with req_addr_i[1:0] ≠ 0, or with any address bit at or above log2(DEPTH_WORDS)+2 set, responds with rsp_err_o = 1 and rsp_rdata_o = 0.
  - A faulting write does not modify the array.
- Undefined:
  - Upper address bits wrap modulo DEPTH_WORDS and addr[1:0] is ignored.
  - rsp_err_o is tied 0.

## Structure
- Package dmem_pkg:
  - rsp_t struct {rdata, err}
  - req_t struct {we, addr, wdata, be}
  - localparam WORD_OFFSET_BITS = 2
- Sub-module sync_fifo:
  - Parameterised by width and depth; clk/reset.
  - Ports push/pop/full/empty/head; registered storage, no bypass.
- The delay line and outstanding counter are implemented in dmem_responder.

## Test plan
- Write 0xDEADBEEF to 0x10 (be = 4'hF), then read 0x10 the next cycle → write response rdata 0, read response 0xDEADBEEF at accept+2.
- Write 0x11223344 to 0x20, then write 0xAA to 0x20 with be = 4'b0010, then read 0x20 → 0x1122AA44.
- Hold rsp_ready_i = 0 and issue 6 back-to-back reads → 4 accepted, req_ready_o = 0, no overflow. Raise rsp_ready_i → 4 in-order responses, then remaining 2 accepted and returned.
- Stream 16 reads with rsp_ready_i = 1 → one accept and one response per cycle after a 2-cycle fill, with correct ordering.
- With DMEM_RESPONDER_ERR_CHECK_EN: read 0x2 → rsp_err_o = 1. Write to 0x1000 (beyond 1024 words) → rsp_err_o = 1 and the array is unchanged. Without the macro: a read of 0x1000 returns word 0.
- Assert reset with 3 requests in flight → next cycle rsp_valid_o = 0, req_ready_o = 1. Previously accepted writes remain readable.
